// File: rtl/demux12_fredkin.sv
// Reversible 1:2 demultiplexer: one Fredkin gate per bit (C tied to ancilla 0),
// a registered valid/ready output stage, per-channel counters and an un-compute self-check.
module demux12_fredkin #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_anc,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] garbage,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             anc_err,
  output logic             rev_err
);

  // Handshake: a word moves across an interface in every cycle where its valid
  // and ready are both 1; valid never depends on ready, in_ready depends only
  // on the held flag and the ready of the channel the held word is bound for.

  logic             held_q, held_d;
  logic             sel_q;
  logic [WIDTH-1:0] p_q, q_q, r_q, shadow_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic             anc_err_q, rev_err_q;

  logic [WIDTH-1:0] fa, fp, fq, fr;
  logic [WIDTH-1:0] up, uq, ur;
  logic             sel_ready, drain, accept, anc_bad, load, mismatch;

  // Forward Fredkin rank: A=sel, B=data, C=anc
  assign fa = {WIDTH{in_sel}};
  assign fp = fa;
  assign fq = (~fa & in_data) | (fa & in_anc);
  assign fr = (fa & in_data) | (~fa & in_anc);

  // Second rank fed with the held (P,Q,R) must restore (sel, data, 0)
  assign up = p_q;
  assign uq = (~p_q & q_q) | (p_q & r_q);
  assign ur = (p_q & q_q) | (~p_q & r_q);
  assign mismatch = (up != {WIDTH{sel_q}}) || (uq != shadow_q) || (ur != '0);

  assign sel_ready = sel_q ? out1_ready : out0_ready;
  assign drain     = held_q & sel_ready;
  assign in_ready  = ~held_q | sel_ready;
  assign accept    = in_valid & in_ready;
  assign anc_bad   = (in_anc != '0);
  assign load      = accept & ~anc_bad;

  always_comb begin
    held_d = held_q;
    if (load)       held_d = 1'b1;
    else if (drain) held_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q    <= 1'b0;
      sel_q     <= 1'b0;
      p_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      shadow_q  <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      anc_err_q <= 1'b0;
      rev_err_q <= 1'b0;
    end else begin
      held_q <= held_d;
      if (load) begin
        sel_q    <= in_sel;
        p_q      <= fp;
        q_q      <= fq;
        r_q      <= fr;
        shadow_q <= in_data;
      end
      if (drain && !sel_q) cnt0_q <= cnt0_q + CNT_W'(1);
      if (drain && sel_q)  cnt1_q <= cnt1_q + CNT_W'(1);
      anc_err_q <= anc_err_q | (accept & anc_bad);
      rev_err_q <= rev_err_q | (held_q & mismatch);
    end
  end

  // Data and garbage read as zero whenever nothing is held
  assign out0_valid = held_q & ~sel_q;
  assign out1_valid = held_q & sel_q;
  assign out0_data  = held_q ? q_q : '0;
  assign out1_data  = held_q ? r_q : '0;
  assign garbage    = held_q ? p_q : '0;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
  assign anc_err    = anc_err_q;
  assign rev_err    = rev_err_q;

endmodule

// File: doc/demux12_fredkin.md
# demux12_fredkin

Reversible 1:2 demultiplexer: routes a WIDTH-bit word to one of two output channels using one Fredkin gate per bit, with the constant input C tied to the ancilla value 0. It is the inverse-direction companion of the Fredkin 2:1 mux: the gate's Q output carries the word for destination 0 and its R output carries the word for destination 1. The block adds a registered valid/ready datapath, per-destination transfer counters and a reversibility self-check that un-computes every routed word through a second Fredkin rank.

## Interface
Parameters:
- WIDTH, 8, data word width; one Fredkin gate per bit.
- CNT_W, 16, width of each per-destination transfer counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept an input word.
- in_sel  input  1  destination select; 0 selects out0, 1 selects out1. Drives Fredkin A on every bit.
- in_data  input  WIDTH  word to route. Drives Fredkin B.
- in_anc  input  WIDTH  ancilla word. Drives Fredkin C; must be all-zero for legal use.
- out0_valid / out0_ready  output / input  1  channel-0 handshake.
- out0_data  output  WIDTH  channel-0 word, taken from Fredkin Q.
- out1_valid / out1_ready  output / input  1  channel-1 handshake.
- out1_data  output  WIDTH  channel-1 word, taken from Fredkin R.
- garbage  output  WIDTH  registered Fredkin P of the held word; every bit equals the held sel.
- cnt0, cnt1  output  CNT_W  number of completed transfers on each channel.
- anc_err  output  1  sticky flag: a word was accepted with a nonzero in_anc.
- rev_err  output  1  sticky flag: the un-compute check mismatched.

## Operation
- Fredkin behaviour per bit, with A=sel, B=data and C=anc:
  - P = A.
  - If A=0: Q = B and R = C.
  - If A=1: Q = C and R = B.
  - With C=0 this gives Q = ~sel&data and R = sel&data.
- An accept occurs when in_valid and in_ready are both 1.
- On accept with in_anc==0: the output register loads Q, R, P and sel, and the held flag goes to 1.
- On accept with in_anc!=0: the word is dropped. anc_err is set, no output is produced, the counters do not change and the held state is unchanged.
- Output channels:
  - out0_valid = held & ~held_sel and out1_valid = held & held_sel; never both 1.
  - out0_data = held Q and out1_data = held R. The unselected channel's data is 0.
- Completion: a transfer completes when the valid of the selected channel and its matching ready are both 1. On completion the selected counter increments, wrapping from 2^CNT_W-1 to 0.
- in_ready = ~held | (selected channel ready). This gives full throughput: a new word can be loaded in the same cycle the held word drains.
- Un-compute check:
  - Every cycle that held=1, the held (P,Q,R) passes through a second Fredkin rank.
  - The result must equal (sel-replicated, original data, 0). The block stores the original data in a shadow register for this comparison.
  - Any mismatch sets rev_err.
- Sticky flags: anc_err and rev_err stay set until rst.
- The unselected channel's ready is ignored.

## Timing
- Reset values: held=0, both out*_valid=0, out0_data=out1_data=0, garbage=0, cnt0=cnt1=0, anc_err=0, rev_err=0.
- in_ready is 1 after reset and is combinational from held and the out*_ready inputs.
- Latency: a word accepted in cycle N appears on its channel's valid and data in cycle N+1.
- Backpressure: while the selected ready is 0, the held word, the valid and the garbage output are stable, and in_ready=0.
- Simultaneous drain and accept in the same cycle: the counter increments for the old word and the register loads the new word. There is no bubble.
- Simultaneous drain and an illegal (nonzero-ancilla) accept: the old word completes, held falls to 0 and anc_err sets.
- Reset mid-operation: the held word is discarded and all outputs go to their reset values asynchronously.

## Test plan
- Route to channel 0: WIDTH=8, in_sel=0, in_data=0xA5, in_anc=0, out0_ready=1 → one cycle later out0_valid=1, out0_data=0xA5, out1_data=0, garbage=0x00; cnt0=1 after the handshake.
- Route to channel 1: in_sel=1, in_data=0x3C → out1_valid=1, out1_data=0x3C, out0_data=0, garbage=0xFF; cnt1=1; rev_err stays 0.
- Backpressure: out1_ready held at 0 for 5 cycles with in_valid=1 → in_ready=0, data stable and cnt1 unchanged. Then out1_ready=1 → the held word drains and the next word loads in the same cycle.
- Illegal ancilla: in_anc=0x01 with in_valid=1 → anc_err=1, no output valid, counters unchanged, anc_err remains set.
- Back-to-back throughput: 100 words with random sel and both readies at 1 → one transfer per cycle, cnt0+cnt1=100, rev_err=0. Also run with CNT_W=4 and 20 transfers to channel 0 → cnt0=4 (wrap).
- Reset mid-operation: assert rst while a word is held → all outputs return to their reset values immediately. After release, in_ready=1.
